fetch_unit: RTL

Instruction fetch stage for the Tron datapath. Holds the program counter and issues single-outstanding reads to instruction memory. Captures the returned 16-bit word into the instruction register and presents it, with a valid/ready handshake, to the decoder that sits directly downstream. Supports a single-cycle redirect from execute for branches and jumps, which squashes any in-flight fetch.

---
 rtl/tron_pkg.sv | 38 +++
 rtl/fetch_unit.sv | 96 +++++++++
 2 files changed

// File: rtl/tron_pkg.sv
// Shared Tron datapath definitions: instruction width, NOP encoding,
// opcode map and the fetch stage state encoding.
package tron_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'hE000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HOLD
  } fetch_state_e;

  // Opcode lives in instr[15:12]; the decoder uses the same constants.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JAL  = 4'hB;
  localparam logic [3:0] OP_SHL  = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 4];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Tron instruction fetch: PC, single-outstanding imem read, instruction
// register with valid/ready handoff to decode, and redirect/squash.
module fetch_unit
  import tron_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_rvalid,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              capture;
  logic              release_ir;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    capture    = 1'b0;
    release_ir = 1'b0;
    unique case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redirect) pc_nxt = redirect_pc;
      end
      REQ: begin
        // The request strobed this cycle is in flight either way.
        state_nxt = redirect ? DRAIN : WAIT;
        if (redirect) pc_nxt = redirect_pc;
      end
      WAIT: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          state_nxt = mem_rvalid ? REQ : DRAIN;
        end else if (mem_rvalid) begin
          capture   = 1'b1;
          pc_nxt    = pc + ADDR_W'(1);
          state_nxt = HOLD;
        end
      end
      DRAIN: begin
        // Any response here retires the one outstanding read, so it ends
        // the drain even when a redirect lands in the same cycle.
        if (redirect) pc_nxt = redirect_pc;
        if (mem_rvalid) state_nxt = REQ;
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt     = redirect_pc;
          release_ir = 1'b1;
          state_nxt  = REQ;
        end else if (ir_valid && ir_ready) begin
          release_ir = 1'b1;
          state_nxt  = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= NOP_INSTR;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture) begin
        ir       <= mem_rdata;
        ir_pc    <= pc;
        ir_valid <= 1'b1;
      end else if (release_ir) begin
        ir_valid <= 1'b0;
      end
    end
  end

  assign mem_req  = (state == REQ);
  assign mem_addr = pc;

endmodule
